svo_tmds_gearbox: RTL
=====================

# svo_tmds_gearbox

Downstream neighbour of the TMDS encoder: takes one 10-bit TMDS symbol per channel (three channels) at word rate and emits two bits per channel per clock for a 5x-rate DDR output primitive. It runs in the half-serial clock domain, where one symbol lasts 5 clocks. It absorbs word-strobe jitter with a one-deep holding register, inserts a control token on underrun, and reports underrun and overrun through sticky flags.

## Interface
Parameters:
- TOKEN, 10'b1101010100, symbol emitted when no data word is available (ctrl=00 token).

Ports:
- clk  in  1  half-serial clock (5x word rate)
- resetn  in  1  synchronous, active-low reset
- in_valid  in  1  one-cycle strobe: in_data0..2 hold a new symbol set
- in_data0  in  10  channel 0 symbol, LSB transmitted first
- in_data1  in  10  channel 1 symbol
- in_data2  in  10  channel 2 symbol
- out_data0  out  2  channel 0 bit pair; bit 0 transmitted first
- out_data1  out  2  channel 1 bit pair
- out_data2  out  2  channel 2 bit pair
- underrun  out  1  sticky: a reload found no word after the first word was accepted
- overrun  out  1  sticky: a word was overwritten before it was consumed
- clear_flags  in  1  clears both sticky flags

## Operation
- The phase counter runs 0..4 and wraps 4->0. It is free-running from reset.
- Each channel has a 10-bit shift register. On every non-reload edge it shifts right by 2 and out_dataN <= shift[1:0].
- A reload edge is an edge where phase==4. On a reload edge, out_dataN <= shift[1:0] (bits 9:8 of the old symbol), and the shift register loads from a source chosen by priority:
  1. holding register, if full=1;
  2. in_data directly (bypass), if full=0 and in_valid=1;
  3. TOKEN, otherwise.
- The holding register captures in_data on in_valid and sets full, except when the same reload edge bypasses the word.
- A reload that consumes the holding register clears full, unless in_valid is 1 on that edge. In that case the new word is captured and full stays 1. This is not an overrun.
- Overrun: in_valid=1 while full=1 and no reload edge. The new word overwrites the old one, full stays 1, and overrun sets.
- Underrun: the reload selects TOKEN while started=1. started sets on the first accepted in_valid after reset.
- TOKEN loads before the first word never flag underrun.
- clear_flags clears both flags. If clear_flags and a new flag event occur on the same edge, the event wins and the flag ends at 1.
- All three channels always share the phase, the source selection, and the flag logic.

## Timing
- Reset state: phase=0, all shift registers=TOKEN, holding register=0, full=0, started=0, out_data0..2=2'b00, underrun=0, overrun=0.
- Asserting resetn low mid-symbol restores the reset state on the next edge. The partial symbol is discarded.
- Latency: a word bypassed or reloaded on a reload edge E presents bits[1:0] after edge E+1 and bits[9:8] after edge E+5.
- Steady state needs exactly one in_valid per 5 clocks. The in_valid phase is arbitrary but must be constant.
- No backpressure: in_valid is always accepted.

## Configuration
- SVO_TMDS_GEARBOX_CLKCH_EN defined:
  - adds port out_clk (out, 2 bits), registered like the data outputs;
  - by the phase of the pair on out_data, out_clk shows 2'b00, 2'b00, 2'b10, 2'b11, 2'b11 (pattern 10'b1111100000, LSB first);
  - out_clk resets to 2'b00.
- Undefined: port absent, no clock-channel logic.

## Test plan
- Reset then idle 20 clocks -> each channel repeats pairs 00,01,01,01,11 (TOKEN LSB-first); underrun=0 and overrun=0.
- Feed 10'h3FF/10'h000/10'h155 every 5 clocks, in_valid at phase 2 -> channels show continuous 11 / 00 / 01 pairs after the first reload; no flags.
- in_valid pulsed exactly on a phase-4 edge with full=0 -> word bypassed; its bits[1:0] appear after the next edge; full stays 0.
- Skip one strobe in the stream -> one TOKEN symbol is inserted and underrun=1 is held. Pulse clear_flags -> underrun=0.
- Two strobes at phase 1 and phase 2 in one frame -> the phase-2 word is transmitted, the phase-1 word is lost, and overrun=1.
- With SVO_TMDS_GEARBOX_CLKCH_EN defined: out_clk sequence is 00,00,10,11,11, aligned to the data symbol boundary. Assert resetn low mid-symbol -> all outputs are 00 the next cycle and the phase restarts at 0.

Source files
------------

// File: rtl/svo_tmds_gearbox.sv
// TMDS 10:2 gearbox for a 5x-rate DDR serializer: one-deep word holding register,
// TOKEN insertion on underrun, sticky flags. Define SVO_TMDS_GEARBOX_CLKCH_EN to add out_clk.
module svo_tmds_gearbox #(
    parameter logic [9:0] TOKEN = 10'b1101010100
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       in_valid,
    input  logic [9:0] in_data0,
    input  logic [9:0] in_data1,
    input  logic [9:0] in_data2,
    output logic [1:0] out_data0,
    output logic [1:0] out_data1,
    output logic [1:0] out_data2,
`ifdef SVO_TMDS_GEARBOX_CLKCH_EN
    output logic [1:0] out_clk,
`endif
    output logic       underrun,
    output logic       overrun,
    input  logic       clear_flags
);

    logic [2:0]       phase_q, phase_d;
    logic [2:0][9:0]  shift_q, shift_d;
    logic [2:0][9:0]  hold_q, hold_d;
    logic [2:0][1:0]  out_q, out_d;
    logic [2:0][9:0]  din;
    logic             full_q, full_d;
    logic             started_q, started_d;
    logic             underrun_q, underrun_d;
    logic             overrun_q, overrun_d;
    logic             reload, capture, under_ev, over_ev;

    assign din = {in_data2, in_data1, in_data0};

    always_comb begin
        reload  = (phase_q == 3'd4);
        phase_d = reload ? 3'd0 : phase_q + 3'd1;
        // A word arriving on a reload edge with an empty holder goes straight to the shifter.
        capture = in_valid && !(reload && !full_q);
        shift_d = shift_q;
        out_d   = out_q;
        for (int c = 0; c < 3; c++) begin
            out_d[c] = shift_q[c][1:0];
            if (reload) begin
                if (full_q)        shift_d[c] = hold_q[c];
                else if (in_valid) shift_d[c] = din[c];
                else               shift_d[c] = TOKEN;
            end else begin
                shift_d[c] = {2'b00, shift_q[c][9:2]};
            end
        end
        hold_d    = capture ? din : hold_q;
        full_d    = capture ? 1'b1 : (reload ? 1'b0 : full_q);
        started_d = started_q | in_valid;
        under_ev  = reload && !full_q && !in_valid && started_q;
        over_ev   = in_valid && full_q && !reload;
        underrun_d = under_ev | (underrun_q & ~clear_flags);
        overrun_d  = over_ev  | (overrun_q  & ~clear_flags);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            phase_q    <= 3'd0;
            shift_q    <= {3{TOKEN}};
            hold_q     <= '0;
            out_q      <= '0;
            full_q     <= 1'b0;
            started_q  <= 1'b0;
            underrun_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            shift_q    <= shift_d;
            hold_q     <= hold_d;
            out_q      <= out_d;
            full_q     <= full_d;
            started_q  <= started_d;
            underrun_q <= underrun_d;
            overrun_q  <= overrun_d;
        end
    end

    assign out_data0 = out_q[0];
    assign out_data1 = out_q[1];
    assign out_data2 = out_q[2];
    assign underrun  = underrun_q;
    assign overrun   = overrun_q;

`ifdef SVO_TMDS_GEARBOX_CLKCH_EN
    logic [1:0] clk_q, clk_d;

    // Clock channel is 10'b1111100000 LSB-first, indexed by the pair being registered.
    always_comb begin
        clk_d = 2'b00;
        case (phase_q)
            3'd2:       clk_d = 2'b10;
            3'd3, 3'd4: clk_d = 2'b11;
            default:    clk_d = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) clk_q <= 2'b00;
        else         clk_q <= clk_d;
    end

    assign out_clk = clk_q;
`endif

endmodule
